// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port between icache and dcache misses; grant registered, RAM driven the cycle after a request, wait held high until ramstate ACCESS.
// Optional STARVE_GUARD_EN macro bounds consecutive dcache grants while the icache is waiting.
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state_q, state_d;
  logic   d_req;
  logic   ram_done;
  logic   starve_grant;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS);
  assign iload    = ramload;
  assign dload    = ramload;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && !iREN) begin
      cnt_d = '0;
    end else if (state_d == IGRANT && state_q != IGRANT) begin
      cnt_d = '0;
    end else if (state_q == DGRANT && d_req && ram_done && iREN &&
                 cnt_q != CNT_W'(STARVE_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_grant = iREN && (cnt_q == CNT_W'(STARVE_MAX));
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
  assign starve_grant      = 1'b0;
`endif

  // RAM outputs decode from the registered grant; a dropped request aborts
  // immediately so the RAM never sees a stale access.
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IDLE: begin
        if (starve_grant) begin
          state_d = IGRANT;
        end else if (d_req) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ram_done) begin
            dwait   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ram_done) begin
            iwait   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: per-cycle vector table plus reset and starvation sequences.
module tb_cache_mem_arbiter;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iw;
    logic        e_dw;
    logic        e_rr;
    logic        e_rw;
    logic [31:0] e_ra;
    logic [31:0] e_rs;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];
  vec_t exp_q [$];
  logic exp_who [$];   // 0 = dcache completion, 1 = icache completion

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] ds, logic [1:0] rs,
                              logic [31:0] rl, logic e_iw, logic e_dw, logic e_rr,
                              logic e_rw, logic [31:0] e_ra, logic [31:0] e_rs);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.e_iw = e_iw; v.e_dw = e_dw; v.e_rr = e_rr;
    v.e_rw = e_rw; v.e_ra = e_ra; v.e_rs = e_rs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = RS_FREE;
  endtask

  initial begin
    vec_t v;
    logic got;

    //            ir ia      dr dw da      ds      rs       rl            iw dw rr rw ra      rst
    vecs[0]  = mk(0, 32'h00, 0, 0, 32'h00, 32'h00, RS_FREE, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[1]  = mk(1, 32'h40, 0, 0, 32'h00, 32'h00, RS_BUSY, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[2]  = mk(1, 32'h40, 0, 0, 32'h00, 32'h00, RS_BUSY, 32'h0,        1, 1, 1, 0, 32'h40, 32'h0000);
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = mk(1, 32'h40, 0, 0, 32'h00, 32'h00, RS_ACC,  32'hDEADBEEF, 0, 1, 1, 0, 32'h40, 32'h0000);
    vecs[6]  = mk(0, 32'h40, 0, 0, 32'h00, 32'h00, RS_FREE, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[7]  = mk(1, 32'h40, 0, 1, 32'h80, 32'h1234, RS_FREE, 32'h0,      1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[8]  = mk(1, 32'h40, 0, 1, 32'h80, 32'h1234, RS_BUSY, 32'h0,      1, 1, 0, 1, 32'h80, 32'h1234);
    vecs[9]  = mk(1, 32'h40, 0, 1, 32'h80, 32'h1234, RS_ACC,  32'h11111111, 1, 0, 0, 1, 32'h80, 32'h1234);
    vecs[10] = mk(1, 32'h40, 0, 0, 32'h80, 32'h1234, RS_FREE, 32'h0,      1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[11] = mk(1, 32'h40, 0, 0, 32'h80, 32'h1234, RS_ACC,  32'hCAFEF00D, 0, 1, 1, 0, 32'h40, 32'h0000);
    vecs[12] = mk(0, 32'h40, 1, 0, 32'h84, 32'h55, RS_FREE, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[13] = mk(0, 32'h40, 1, 0, 32'h84, 32'h55, RS_ERR,  32'h0,        1, 1, 1, 0, 32'h84, 32'h0055);
    vecs[14] = vecs[13];
    vecs[15] = mk(0, 32'h40, 1, 0, 32'h84, 32'h55, RS_ACC,  32'h0BADF00D, 1, 0, 1, 0, 32'h84, 32'h0055);
    vecs[16] = mk(0, 32'h40, 1, 0, 32'h84, 32'h55, RS_ACC,  32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[17] = mk(0, 32'h40, 1, 1, 32'h84, 32'h55, RS_ACC,  32'h22222222, 1, 0, 0, 1, 32'h84, 32'h0055);
    vecs[18] = mk(0, 32'h00, 0, 0, 32'h00, 32'h00, RS_FREE, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[19] = mk(1, 32'h44, 0, 0, 32'h00, 32'h00, RS_BUSY, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[20] = mk(1, 32'h44, 0, 0, 32'h00, 32'h00, RS_BUSY, 32'h0,        1, 1, 1, 0, 32'h44, 32'h0000);
    vecs[21] = mk(0, 32'h44, 0, 0, 32'h00, 32'h00, RS_BUSY, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[22] = mk(0, 32'h44, 0, 0, 32'h00, 32'h00, RS_ACC,  32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[23] = mk(0, 32'h00, 1, 0, 32'h88, 32'h00, RS_FREE, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[24] = mk(0, 32'h00, 0, 0, 32'h88, 32'h00, RS_ACC,  32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);
    vecs[25] = mk(0, 32'h00, 0, 0, 32'h00, 32'h00, RS_FREE, 32'h0,        1, 1, 0, 0, 32'h00, 32'h0000);

    // Reset state
    nRST = 0;
    drive_idle();
    #12;
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    @(negedge CLK);
    nRST = 1;

    // Cycle-by-cycle vector table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      v = vecs[i];
      iREN = v.ir; iaddr = v.ia; dREN = v.dr; dWEN = v.dw; daddr = v.da;
      dstore = v.ds; ramstate = v.rs; ramload = v.rl;
      exp_q.push_back(v);
      #1;
      v = exp_q.pop_front();
      chk($sformatf("v%0d_iwait", i), {31'd0, iwait}, {31'd0, v.e_iw});
      chk($sformatf("v%0d_dwait", i), {31'd0, dwait}, {31'd0, v.e_dw});
      chk($sformatf("v%0d_ramREN", i), {31'd0, ramREN}, {31'd0, v.e_rr});
      chk($sformatf("v%0d_ramWEN", i), {31'd0, ramWEN}, {31'd0, v.e_rw});
      chk($sformatf("v%0d_ramaddr", i), ramaddr, v.e_ra);
      chk($sformatf("v%0d_ramstore", i), ramstore, v.e_rs);
      chk($sformatf("v%0d_iload", i), iload, v.rl);
      chk($sformatf("v%0d_dload", i), dload, v.rl);
    end
    chk("vec_queue_empty", exp_q.size(), 32'd0);

    // Reset asserted while a dcache write is granted
    @(negedge CLK);
    drive_idle();
    dWEN = 1; daddr = 32'h90; dstore = 32'h77; ramstate = RS_BUSY;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge CLK);
      #1;
      if (ramWEN) got = 1;
    end
    chk("rstmid_wen_seen", {31'd0, got}, 32'd1);
    nRST = 0;
    #1;
    chk("rstmid_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rstmid_dwait", {31'd0, dwait}, 32'd1);
    chk("rstmid_ramaddr", ramaddr, 32'd0);
    @(negedge CLK);
    nRST = 1;
    #1;
    chk("rstmid_idle_wen", {31'd0, ramWEN}, 32'd0);
    chk("rstmid_idle_addr", ramaddr, 32'd0);
    dWEN = 0;
    ramstate = RS_FREE;

    // Continuous dcache and icache demand: expected completion order
`ifdef STARVE_GUARD_EN
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) exp_who.push_back(1'b0);
      exp_who.push_back(1'b1);
    end
`else
    for (int k = 0; k < 20; k++) exp_who.push_back(1'b0);
`endif
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        dREN = 1; iREN = 1; daddr = 32'hA0; iaddr = 32'hB0; ramstate = RS_ACC;
      end
      #1;
      if (!dwait || !iwait) begin
        if (!dwait && !iwait) begin
          chk($sformatf("starve_c%0d_both_waits_low", c), 32'd1, 32'd0);
        end else if (exp_who.size() == 0) begin
          chk($sformatf("starve_c%0d_extra_completion", c), {31'd0, !iwait}, 32'hFFFFFFFF);
        end else begin
          chk($sformatf("starve_c%0d_owner", c), {31'd0, !iwait}, {31'd0, exp_who.pop_front()});
        end
      end
    end
    chk("starve_remaining", exp_who.size(), 32'd0);
    @(negedge CLK);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
